// File: rtl/multicycle_decode_fsm.sv
// Multicycle ARM main controller: state FSM, ALU decoder and PC-write logic.
// Optional DECODE_MEMWAIT_EN adds mem_ready wait states to FETCH, MEMRD and MEMWR.
module multicycle_decode_fsm #(
  parameter int REG_ADDR_W = 4,
  parameter int ALUCTRL_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [REG_ADDR_W-1:0] Rd,
`ifdef DECODE_MEMWAIT_EN
  input  logic                  mem_ready,
`endif
  output logic [1:0]            FlagW,
  output logic                  PCS,
  output logic                  NextPC,
  output logic                  RegW,
  output logic                  MemW,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALUCTRL_W-1:0]  ALUControl,
  output logic                  Illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t     state, next;
  logic       nowrite_q, illegal_q, mem_ok;
  logic [2:0] dec_alu, alu3;
  logic       dec_nowrite, dec_illegal, dec_cv, branch;

`ifdef DECODE_MEMWAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // dec_cv marks the arithmetic ops whose carry/overflow are meaningful
  always_comb begin
    dec_alu     = 3'b000;
    dec_nowrite = 1'b0;
    dec_illegal = 1'b0;
    dec_cv      = 1'b0;
    case (Funct[4:1])
      4'b0100: dec_cv = 1'b1;
      4'b0010: begin dec_alu = 3'b001; dec_cv = 1'b1; end
      4'b0000: dec_alu = 3'b010;
      4'b1100: dec_alu = 3'b011;
      4'b0001: dec_alu = 3'b100;
      4'b1010: begin dec_alu = 3'b001; dec_cv = 1'b1; dec_nowrite = 1'b1; end
      4'b1011: begin dec_cv = 1'b1; dec_nowrite = 1'b1; end
      4'b1000: begin dec_alu = 3'b010; dec_nowrite = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      nowrite_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE) begin
        nowrite_q <= (Op == 2'b00) & dec_nowrite;
        illegal_q <= (Op == 2'b00) & dec_illegal;
      end
    end
  end

  always_comb begin
    next       = state;
    FlagW      = 2'b00;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    Illegal    = 1'b0;
    branch     = 1'b0;
    alu3       = 3'b000;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ok;
        NextPC    = mem_ok;
        if (mem_ok) next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   next = MEMADR;
          2'b10:   next = BRANCH;
          default: begin next = FETCH; Illegal = 1'b1; end
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        next    = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ok) next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        next      = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (mem_ok) next = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB = (state == EXECUTEI) ? 2'b01 : 2'b00;
        alu3    = dec_alu;
        FlagW   = {Funct[0] & ~illegal_q, Funct[0] & dec_cv};
        Illegal = illegal_q;
        next    = ALUWB;
      end
      ALUWB: begin
        RegW    = ~(nowrite_q | illegal_q);
        Illegal = illegal_q;
        next    = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        next      = FETCH;
      end
      default: next = FETCH;
    endcase

    ImmSrc        = Op;
    RegSrc        = {Op == 2'b01, Op == 2'b10};
    ALUControl    = '0;
    ALUControl[2:0] = alu3;
    PCS           = ((Rd == {REG_ADDR_W{1'b1}}) & RegW) | branch;

    // Reset overrides everything so no strobe leaks while the FSM is held
    if (!reset) begin
      FlagW      = 2'b00;
      PCS        = 1'b0;
      NextPC     = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
      ALUControl = '0;
      Illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_decode_fsm.sv
// Directed bench for multicycle_decode_fsm: one task per instruction class.
module tb_multicycle_decode_fsm;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs, nextpc, regw, memw, irwrite, adrsrc, alusrca;
    logic [1:0] resultsrc, alusrcb, immsrc, regsrc;
    logic [2:0] aluctrl;
    logic       illegal;
  } outs_t;

  logic       clk, reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
`ifdef DECODE_MEMWAIT_EN
  logic       mem_ready;
`endif
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, Illegal;
  logic [2:0] ALUControl;
  outs_t      obs;
  int         checks, passed;

  multicycle_decode_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
`ifdef DECODE_MEMWAIT_EN
    .mem_ready(mem_ready),
`endif
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .Illegal(Illegal)
  );

  assign obs = {FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA,
                ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t base(input logic [1:0] op);
    outs_t o;
    o = '0;
    o.immsrc = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    return o;
  endfunction

  function automatic outs_t fetch_e(input logic [1:0] op);
    outs_t o;
    o = base(op);
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
    o.irwrite = 1'b1; o.nextpc = 1'b1;
    return o;
  endfunction

  function automatic outs_t decode_e(input logic [1:0] op);
    outs_t o;
    o = base(op);
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
    return o;
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (obs !== '0) $display("FAIL reset_low: got %h want 0", obs);
    else passed++;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (obs !== '0) $display("FAIL reset_held: got %h want 0", obs);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_add();
    outs_t e[4];
    Op = 2'b00; Funct = 6'b001000; Rd = 4'd1;
    e[0] = fetch_e(2'b00);
    e[1] = decode_e(2'b00);
    e[2] = base(2'b00);
    e[3] = base(2'b00); e[3].regw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) $display("FAIL add cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cmp();
    outs_t e[4];
    Op = 2'b00; Funct = 6'b010101; Rd = 4'd3;
    e[0] = fetch_e(2'b00);
    e[1] = decode_e(2'b00);
    e[2] = base(2'b00); e[2].aluctrl = 3'b001; e[2].flagw = 2'b11;
    e[3] = base(2'b00);
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) $display("FAIL cmp cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_eor_imm_pc();
    outs_t e[4];
    Op = 2'b00; Funct = 6'b100011; Rd = 4'd15;
    e[0] = fetch_e(2'b00);
    e[1] = decode_e(2'b00);
    e[2] = base(2'b00); e[2].alusrcb = 2'b01; e[2].aluctrl = 3'b100; e[2].flagw = 2'b10;
    e[3] = base(2'b00); e[3].regw = 1'b1; e[3].pcs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) $display("FAIL eor_imm cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldr();
    outs_t e[8];
    logic  rdy[8];
    int    n;
    outs_t rd_e, wb_e;
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd15;
    rd_e = base(2'b01); rd_e.adrsrc = 1'b1;
    wb_e = base(2'b01); wb_e.resultsrc = 2'b01; wb_e.regw = 1'b1; wb_e.pcs = 1'b1;
    for (int i = 0; i < 8; i++) rdy[i] = 1'b1;
`ifdef DECODE_MEMWAIT_EN
    n = 8;
    e[0] = fetch_e(2'b01); e[0].irwrite = 1'b0; e[0].nextpc = 1'b0; rdy[0] = 1'b0;
    e[1] = fetch_e(2'b01);
    e[2] = decode_e(2'b01);
    e[3] = base(2'b01); e[3].alusrcb = 2'b01;
    e[4] = rd_e; rdy[4] = 1'b0;
    e[5] = rd_e; rdy[5] = 1'b0;
    e[6] = rd_e;
    e[7] = wb_e;
`else
    n = 5;
    e[0] = fetch_e(2'b01);
    e[1] = decode_e(2'b01);
    e[2] = base(2'b01); e[2].alusrcb = 2'b01;
    e[3] = rd_e;
    e[4] = wb_e;
`endif
    for (int i = 0; i < n; i++) begin
`ifdef DECODE_MEMWAIT_EN
      mem_ready = rdy[i];
`endif
      #1; checks++;
      if (obs !== e[i]) $display("FAIL ldr cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
`ifdef DECODE_MEMWAIT_EN
    mem_ready = 1'b1;
`endif
  endtask

  task automatic test_branch();
    outs_t e[3];
    Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
    e[0] = fetch_e(2'b10);
    e[1] = decode_e(2'b10);
    e[2] = base(2'b10); e[2].alusrcb = 2'b01; e[2].resultsrc = 2'b10; e[2].pcs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs !== e[i]) $display("FAIL branch cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_op();
    outs_t e[2];
    Op = 2'b11; Funct = 6'b000000; Rd = 4'd15;
    e[0] = fetch_e(2'b11);
    e[1] = decode_e(2'b11); e[1].illegal = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (obs !== e[i]) $display("FAIL illegal_op cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_dp();
    outs_t e[4];
    Op = 2'b00; Funct = 6'b001101; Rd = 4'd15;
    e[0] = fetch_e(2'b00);
    e[1] = decode_e(2'b00);
    e[2] = base(2'b00); e[2].illegal = 1'b1;
    e[3] = base(2'b00); e[3].illegal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) $display("FAIL illegal_dp cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    outs_t e[4];
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
    e[0] = fetch_e(2'b01);
    e[1] = decode_e(2'b01);
    e[2] = base(2'b01); e[2].alusrcb = 2'b01;
    e[3] = base(2'b01); e[3].adrsrc = 1'b1; e[3].memw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) $display("FAIL str cyc%0d: got %h want %h", i, obs, e[i]);
      else passed++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b0;
    #1; checks++;
    if (obs !== '0) $display("FAIL abort_async: got %h want 0", obs);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) $display("FAIL abort_held: got %h want 0", obs);
    else passed++;
    reset = 1'b1;
    #1; checks++;
    if (obs !== fetch_e(2'b01)) $display("FAIL abort_release: got %h want %h", obs, fetch_e(2'b01));
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (obs !== decode_e(2'b01)) $display("FAIL abort_decode: got %h want %h", obs, decode_e(2'b01));
    else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    reset = 1'b0; Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
`ifdef DECODE_MEMWAIT_EN
    mem_ready = 1'b1;
`endif
    test_reset();
    test_add();
    test_cmp();
    test_eor_imm_pc();
    test_ldr();
    test_branch();
    test_illegal_op();
    test_illegal_dp();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
